// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier operand path.
//   - packer FSM state encoding
//   - default word geometry (64-bit words, 32 words -> 2048-bit operand)
package paillier_pkg;

  localparam int DEF_WORD_WIDTH = 64;
  localparam int DEF_NUM_WORDS  = 32;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } pk_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Drains a fall-through word FIFO and assembles NUM_WORDS consecutive words
// into one wide operand for the Paillier core, presented on valid/ready.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   fifo_rd_data   FIFO head word (valid while fifo_rd_empty==0)
//   fifo_rd_empty  FIFO empty flag
//   fifo_rd_en     pop strobe, head consumed on the same edge (combinational)
//   op_data        assembled operand, word 0 in the LSBs
//   op_valid       op_data complete and stable
//   op_ready       core accepts op_data when op_valid && op_ready
//   fill_cnt       words captured into the current operand (0..NUM_WORDS)
//   busy           partial operand held (0 < fill_cnt < NUM_WORDS)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_FILL | popping words from the FIFO into slot[word_cnt]
// ST_HOLD | operand complete, op_valid high, waiting for op_ready
module fifo_word_packer
  import paillier_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  localparam int CNT_W     = $clog2(NUM_WORDS) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_WIDTH-1:0]           fifo_rd_data,
  input  logic                            fifo_rd_empty,
  output logic                            fifo_rd_en,
  output logic [WORD_WIDTH*NUM_WORDS-1:0] op_data,
  output logic                            op_valid,
  input  logic                            op_ready,
  output logic [CNT_W-1:0]                fill_cnt,
  output logic                            busy
);

  pk_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pop;
  logic [WORD_WIDTH-1:0] slot_q [NUM_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      ST_FILL: begin
        pop = !fifo_rd_empty && !rst;
        if (pop) begin
          // counter reaches NUM_WORDS on the last pop, so fill_cnt can
          // follow cnt_d directly in both states
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // op_valid is always high in HOLD, so op_ready alone is the handshake
        if (op_ready) begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  assign fifo_rd_en = pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      op_valid <= 1'b0;
      fill_cnt <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_valid <= (state_d == ST_HOLD);
      fill_cnt <= cnt_d;
      busy     <= (state_d == ST_FILL) && (cnt_d != '0);
      // slots are written in place by decoded counter value; stale words from
      // the previous operand remain until overwritten
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (pop && (cnt_q == CNT_W'(i))) begin
          slot_q[i] <= fifo_rd_data;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
    assign op_data[g*WORD_WIDTH +: WORD_WIDTH] = slot_q[g];
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

  localparam int W = 8;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  fifo_rd_data = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          fifo_rd_en;
  logic [W*N-1:0] op_data;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [2:0]    fill_cnt;
  logic          busy;

  fifo_word_packer #(.WORD_WIDTH(W), .NUM_WORDS(N)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
    .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
    .fill_cnt(fill_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // sampled DUT outputs (taken 1 ns after the falling edge)
  logic          s_rd_en, s_valid, s_busy;
  logic [2:0]    s_fill;
  logic [31:0]   s_data;
  logic          hs;

  // reference model: number of words captured and the slot contents
  int            m_n = 0;
  logic [7:0]    m_slot [4] = '{default: 8'h00};

  // upstream FIFO (depth 16) and stream of every word written to it
  logic [7:0]    fq [$];
  logic [7:0]    sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic e, input logic [7:0] d, input logic rdy, input logic r);
    logic       exp_rd;
    logic [31:0] exp_data;
    @(negedge clk);
    fifo_rd_empty = e;
    fifo_rd_data  = d;
    op_ready      = rdy;
    rst           = r;
    #1;
    s_rd_en = fifo_rd_en;
    s_valid = op_valid;
    s_busy  = busy;
    s_fill  = fill_cnt;
    s_data  = op_data;
    hs      = s_valid && rdy && !r;
    exp_rd   = !r && !e && (m_n < N);
    exp_data = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
    chk("rd_en",    32'(s_rd_en), 32'(exp_rd));
    chk("op_valid", 32'(s_valid), 32'(m_n == N));
    chk("fill_cnt", 32'(s_fill),  32'(m_n));
    chk("busy",     32'(s_busy),  32'((m_n > 0) && (m_n < N)));
    chk("op_data",  s_data, exp_data);
    total++;
    assert (!(s_rd_en && e)) else begin
      bad++;
      $display("FAIL rd_en_while_empty: rd_en=%b empty=%b", s_rd_en, e);
    end
    @(posedge clk);
    if (r) begin
      m_n = 0;
      for (int i = 0; i < N; i++) m_slot[i] = 8'h00;
    end else if (m_n == N) begin
      if (rdy) m_n = 0;
    end else if (!e) begin
      m_slot[m_n] = d;
      m_n++;
    end
  endtask

  task automatic fstep(input logic rdy);
    logic       e;
    logic [7:0] d;
    e = (fq.size() == 0);
    d = e ? 8'h00 : fq[0];
    tick(e, d, rdy, 1'b0);
    if (s_rd_en && !e) void'(fq.pop_front());
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    sb.push_back(w);
  endtask

  task automatic do_reset();
    tick(1'b1, 8'h00, 1'b0, 1'b1);
    fq.delete();
    sb.delete();
  endtask

  typedef struct {
    logic        e;
    logic [7:0]  d;
    logic        rdy;
    logic        x_rd;
    logic        x_val;
    logic [2:0]  x_fill;
    logic        x_busy;
    logic [31:0] x_data;
  } vec_t;

  vec_t tv [14];
  int   n;
  int   ops;
  int   hs_cyc [$];
  logic [31:0] hs_dat [$];
  logic [31:0] exp4 [3];
  logic [7:0]  w;

  initial begin
    //         e     d      rdy   rd    val   fill  busy  op_data
    tv[0]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h00000000};
    tv[1]  = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 32'h00000011};
    tv[2]  = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 32'h00002211};
    tv[3]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 32'h00332211};
    tv[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 32'h44332211};
    tv[5]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h44332211};
    tv[6]  = '{1'b0, 8'hA1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h44332211};
    tv[7]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 32'h443322A1};
    tv[8]  = '{1'b0, 8'hB2, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 32'h443322A1};
    tv[9]  = '{1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 32'h4433B2A1};
    tv[10] = '{1'b0, 8'hD4, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 32'h44C3B2A1};
    tv[11] = '{1'b0, 8'hE5, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 32'hD4C3B2A1};
    tv[12] = '{1'b0, 8'hE5, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 32'hD4C3B2A1};
    tv[13] = '{1'b0, 8'hE5, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'hD4C3B2A1};

    rst = 1'b1;
    repeat (2) @(posedge clk);

    // table: first operand, stall mid-fill, op_ready ignored in FILL, hold
    for (int i = 0; i < 14; i++) begin
      tick(tv[i].e, tv[i].d, tv[i].rdy, 1'b0);
      chk($sformatf("tv%0d_rd_en", i), 32'(s_rd_en), 32'(tv[i].x_rd));
      chk($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].x_val));
      chk($sformatf("tv%0d_fill", i),  32'(s_fill),  32'(tv[i].x_fill));
      chk($sformatf("tv%0d_busy", i),  32'(s_busy),  32'(tv[i].x_busy));
      chk($sformatf("tv%0d_data", i),  s_data, tv[i].x_data);
    end

    // 8 words, core stalls for 20 cycles
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h51 + i));
    repeat (4) fstep(1'b0);
    for (int i = 0; i < 20; i++) begin
      fstep(1'b0);
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_data", s_data, 32'h54535251);
      chk("hold_fifo_cnt", 32'(fq.size()), 32'd4);
    end
    fstep(1'b1);
    chk("hold_hs", 32'(hs), 32'd1);
    n = 0;
    do begin
      fstep(1'b0);
      n++;
    end while (!s_valid && n < 20);
    chk("second_op_latency", 32'(n), 32'd5);
    chk("second_op_data", s_data, 32'h58575655);
    fstep(1'b1);

    // 2 words, 10-cycle gap, 2 words
    do_reset();
    push(8'h61); push(8'h62);
    repeat (3) fstep(1'b0);
    for (int i = 0; i < 10; i++) begin
      fstep(1'b0);
      chk("gap_busy", 32'(s_busy), 32'd1);
      chk("gap_fill", 32'(s_fill), 32'd2);
      chk("gap_rd_en", 32'(s_rd_en), 32'd0);
    end
    push(8'h63); push(8'h64);
    n = 0;
    do begin
      fstep(1'b0);
      n++;
    end while (!s_valid && n < 10);
    chk("gap_valid", 32'(s_valid), 32'd1);
    chk("gap_data", s_data, 32'h64636261);
    fstep(1'b1);

    // continuous stream of 12 words with op_ready held high
    do_reset();
    for (int i = 1; i <= 12; i++) push(8'(i));
    exp4[0] = 32'h04030201; exp4[1] = 32'h08070605; exp4[2] = 32'h0C0B0A09;
    hs_cyc.delete(); hs_dat.delete();
    for (int c = 0; c < 30; c++) begin
      fstep(1'b1);
      if (hs) begin
        hs_cyc.push_back(c);
        hs_dat.push_back(s_data);
      end
    end
    chk("stream_count", 32'(hs_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < hs_dat.size(); i++) begin
      chk($sformatf("stream_data%0d", i), hs_dat[i], exp4[i]);
      if (i > 0) chk($sformatf("stream_gap%0d", i), 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd5);
    end

    // reset after 3 captured words
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h71 + i));
    repeat (3) fstep(1'b0);
    tick(1'b0, fq[0], 1'b0, 1'b1);
    chk("rst_rd_en", 32'(s_rd_en), 32'd0);
    fq.delete(); sb.delete();
    fstep(1'b0);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_data", s_data, 32'h0);
    chk("rst_fill", 32'(s_fill), 32'd0);
    for (int i = 0; i < 4; i++) push(8'(8'h81 + i));
    n = 0;
    do begin
      fstep(1'b0);
      n++;
    end while (!s_valid && n < 10);
    chk("rst_clean_data", s_data, 32'h84838281);
    fstep(1'b1);

    // random fill/stall mix against the written-word stream
    do_reset();
    ops = 0;
    for (int c = 0; c < 60000 && ops < 1000; c++) begin
      if (fq.size() < 16 && $urandom_range(0, 9) < 7) begin
        w = 8'($urandom);
        push(w);
      end
      fstep(1'($urandom_range(0, 1)));
      if (hs) begin
        if (sb.size() >= 4) begin
          chk("rand_op", s_data, {sb[3], sb[2], sb[1], sb[0]});
          repeat (4) void'(sb.pop_front());
        end else begin
          chk("rand_op_underflow", 32'(sb.size()), 32'd4);
        end
        ops++;
      end
    end
    chk("rand_ops_done", 32'(ops), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
